// File: rtl/flit_sender_if.sv
// Pop-side queue handshake, serial link and response signals of flit_sender.
// master is the sender's view; slave is the queue/link side.
interface flit_sender_if #(
  parameter int FLIT_WIDTH = 64,
  parameter int PHY_WIDTH  = 16
);
  logic                  flit_valid;
  logic [FLIT_WIDTH-1:0] flit_in;
  logic                  flit_ready;
  logic                  tx_valid;
  logic [PHY_WIDTH-1:0]  tx_data;
  logic                  tx_last;
  logic                  tx_ready;
  logic                  ack_valid;
  logic                  ack_ok;
  logic                  sent;
  logic                  dropped;
  logic                  busy;

  modport master (
    input  flit_valid, flit_in, tx_ready, ack_valid, ack_ok,
    output flit_ready, tx_valid, tx_data, tx_last, sent, dropped, busy
  );

  modport slave (
    output flit_valid, flit_in, tx_ready, ack_valid, ack_ok,
    input  flit_ready, tx_valid, tx_data, tx_last, sent, dropped, busy
  );
endinterface

// File: rtl/flit_sender.sv
// Pops one flit, sends it LSB chunk first over the link, and waits for ack/nack,
// retransmitting on nack or timeout up to MAX_RETRY times before dropping it.
module flit_sender #(
  parameter int FLIT_WIDTH = 64,
  parameter int PHY_WIDTH  = 16,
  parameter int TIMEOUT    = 32,
  parameter int MAX_RETRY  = 3
) (
  input  logic          clk,
  input  logic          rst,
  flit_sender_if.master bus
);
  localparam int NCHUNK = FLIT_WIDTH / PHY_WIDTH;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int RTY_W  = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int TMO_W  = $clog2(TIMEOUT + 1);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] SEND     = 2'd1;
  localparam logic [1:0] WAIT_ACK = 2'd2;

  logic [1:0]                       state;
  logic [1:0]                       state_nx;
  logic [FLIT_WIDTH-1:0]            flit_q;
  logic [NCHUNK-1:0][PHY_WIDTH-1:0] chunks;
  logic [IDX_W-1:0]                 idx;
  logic [RTY_W-1:0]                 rty;
  logic [TMO_W-1:0]                 tmo;
  logic                             ready_q;
  logic                             sent_q;
  logic                             dropped_q;
  logic                             last;
  logic                             accept;
  logic                             ack_hit;
  logic                             fail;
  logic                             can_retry;

  assign chunks    = flit_q;
  assign last      = (idx == IDX_W'(NCHUNK - 1));
  assign accept    = (state == IDLE) && ready_q && bus.flit_valid;
  assign ack_hit   = (state == WAIT_ACK) && bus.ack_valid && bus.ack_ok;
  // A response on the final timeout cycle takes precedence over the timeout.
  assign fail      = (state == WAIT_ACK) &&
                     (bus.ack_valid ? !bus.ack_ok : (tmo == TMO_W'(TIMEOUT - 1)));
  assign can_retry = (rty < RTY_W'(MAX_RETRY));

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (accept) state_nx = SEND;
      SEND:     if (bus.tx_ready && last) state_nx = WAIT_ACK;
      WAIT_ACK: begin
        if (ack_hit)   state_nx = IDLE;
        else if (fail) state_nx = can_retry ? SEND : IDLE;
      end
      default:  state_nx = IDLE;
    endcase
  end

  // flit_ready is registered so it stays low through reset and has no input path.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      flit_q    <= '0;
      idx       <= '0;
      rty       <= '0;
      tmo       <= '0;
      ready_q   <= 1'b0;
      sent_q    <= 1'b0;
      dropped_q <= 1'b0;
    end else begin
      state     <= state_nx;
      ready_q   <= (state_nx == IDLE);
      sent_q    <= ack_hit;
      dropped_q <= fail && !can_retry;
      case (state)
        IDLE: begin
          if (accept) begin
            flit_q <= bus.flit_in;
            idx    <= '0;
            rty    <= '0;
          end
        end
        SEND: begin
          if (bus.tx_ready) begin
            if (last) begin
              idx <= '0;
              tmo <= '0;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end
        WAIT_ACK: begin
          if (fail && can_retry) begin
            rty <= rty + RTY_W'(1);
            idx <= '0;
          end else if (!bus.ack_valid) begin
            tmo <= tmo + TMO_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.flit_ready = ready_q;
  assign bus.tx_valid   = (state == SEND);
  assign bus.tx_data    = (state == SEND) ? chunks[idx] : '0;
  assign bus.tx_last    = (state == SEND) && last;
  assign bus.sent       = sent_q;
  assign bus.dropped    = dropped_q;
  assign bus.busy       = (state != IDLE);
endmodule

// File: tb/tb_flit_sender.sv
// Transaction-level bench for flit_sender: predicts chunk stream, response gaps
// and sent/dropped outcome per flit from its response schedule.
module tb_flit_sender;
  localparam int FW  = 64;
  localparam int PW  = 16;
  localparam int NCH = FW / PW;
  localparam int TMO = 32;
  localparam int MR  = 3;

  logic clk = 1'b0;
  logic rst;
  int   errs   = 0;
  int   checks = 0;

  // response schedule per attempt: kind 0 = none, 1 = ack, 2 = nack
  int   rkind [MR+1];
  int   rdly  [MR+1];
  int   rdy_mode;   // 0 always ready, 1 random, 2 pattern
  bit   stray;
  int   pat [5] = '{0, 1, 0, 0, 1};

  flit_sender_if #(.FLIT_WIDTH(FW), .PHY_WIDTH(PW)) bus ();

  flit_sender #(
    .FLIT_WIDTH(FW),
    .PHY_WIDTH (PW),
    .TIMEOUT   (TMO),
    .MAX_RETRY (MR)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "/flit_ready"}, 64'(bus.flit_ready), 64'd0);
    chk({tag, "/tx_valid"},   64'(bus.tx_valid),   64'd0);
    chk({tag, "/tx_last"},    64'(bus.tx_last),    64'd0);
    chk({tag, "/tx_data"},    64'(bus.tx_data),    64'd0);
    chk({tag, "/sent"},       64'(bus.sent),       64'd0);
    chk({tag, "/dropped"},    64'(bus.dropped),    64'd0);
    chk({tag, "/busy"},       64'(bus.busy),       64'd0);
  endtask

  task automatic run_flit(input logic [FW-1:0] flit, input string name);
    logic [PW-1:0] exp_d[$];
    logic          exp_l[$];
    int            exp_gap[$];
    logic [PW-1:0] obs_d[$];
    logic          obs_l[$];
    int            obs_gap[$];
    int            att, exp_sent, exp_drop, nsent, ndrop;
    bit            accepted, acc_prev, in_wait, done, gap_on, stall_prev;
    int            wcnt, gap, a, pidx, kind;
    logic [PW-1:0] prev_d;
    logic          prev_l;
    logic          r;

    // reference: attempts until first ack, or MR+1 attempts then drop
    exp_sent = 0; exp_drop = 1; att = 0;
    for (int k = 0; k <= MR; k++) begin
      att++;
      exp_gap.push_back(rkind[k] == 0 ? TMO : rdly[k] + 1);
      if (rkind[k] == 1) begin
        exp_sent = 1; exp_drop = 0;
        break;
      end
    end
    for (int k = 0; k < att; k++)
      for (int c = 0; c < NCH; c++) begin
        exp_d.push_back(PW'(flit >> (c * PW)));
        exp_l.push_back(c == NCH - 1);
      end

    nsent = 0; ndrop = 0; accepted = 0; acc_prev = 0; in_wait = 0; done = 0;
    gap_on = 0; stall_prev = 0; wcnt = 0; gap = 0; a = 0; pidx = 0;
    prev_d = '0; prev_l = 1'b0;

    for (int cyc = 0; cyc < 4000 && !done; cyc++) begin
      @(negedge clk);
      if (acc_prev) chk({name, "/tx_valid_after_accept"}, 64'(bus.tx_valid), 64'd1);
      if (stall_prev) begin
        chk({name, "/hold_valid"}, 64'(bus.tx_valid), 64'd1);
        chk({name, "/hold_data"},  64'(bus.tx_data),  64'(prev_d));
        chk({name, "/hold_last"},  64'(bus.tx_last),  64'(prev_l));
      end
      if (bus.sent)    nsent++;
      if (bus.dropped) ndrop++;
      if (gap_on) begin
        if (bus.tx_valid || bus.sent || bus.dropped) begin
          obs_gap.push_back(gap);
          gap_on = 0;
        end else begin
          gap++;
        end
      end
      if (bus.sent || bus.dropped) begin
        chk({name, "/pulse_excl"}, 64'(bus.sent & bus.dropped), 64'd0);
        chk({name, "/ready_after"}, 64'(bus.flit_ready), 64'd1);
        chk({name, "/busy_after"},  64'(bus.busy),       64'd0);
        done = 1;
      end

      acc_prev = 0;
      if (!accepted && bus.flit_ready) begin
        bus.flit_valid = 1'b1;
        bus.flit_in    = flit;
        accepted       = 1;
        acc_prev       = 1;
      end else begin
        bus.flit_valid = 1'b0;
        bus.flit_in    = {$urandom, $urandom};
      end

      case (rdy_mode)
        0:       r = 1'b1;
        1:       r = 1'($urandom_range(0, 1));
        default: begin
          r = 1'(pat[pidx % 5]);
          if (bus.tx_valid) pidx++;
        end
      endcase
      bus.tx_ready = r;
      stall_prev   = bus.tx_valid && !r;
      prev_d       = bus.tx_data;
      prev_l       = bus.tx_last;

      bus.ack_valid = 1'b0;
      bus.ack_ok    = 1'b0;
      if (in_wait) begin
        kind = (a <= MR) ? rkind[a] : 0;
        if (kind != 0 && wcnt == rdly[a]) begin
          bus.ack_valid = 1'b1;
          bus.ack_ok    = (kind == 1);
          in_wait = 0; a++;
        end else if (wcnt == TMO - 1) begin
          in_wait = 0; a++;
        end else begin
          wcnt++;
        end
      end else if (stray) begin
        bus.ack_valid = 1'($urandom_range(0, 1));
        bus.ack_ok    = 1'($urandom_range(0, 1));
      end

      if (bus.tx_valid && r) begin
        obs_d.push_back(bus.tx_data);
        obs_l.push_back(bus.tx_last);
        if (bus.tx_last) begin
          in_wait = 1; wcnt = 0; gap_on = 1; gap = 0;
        end
      end
    end

    bus.flit_valid = 1'b0;
    bus.ack_valid  = 1'b0;
    bus.ack_ok     = 1'b0;

    chk({name, "/completed"}, 64'(done), 64'd1);
    chk({name, "/handshakes"}, 64'(obs_d.size()), 64'(exp_d.size()));
    for (int i = 0; i < obs_d.size() && i < exp_d.size(); i++) begin
      chk($sformatf("%s/chunk%0d", name, i), 64'(obs_d[i]), 64'(exp_d[i]));
      chk($sformatf("%s/last%0d", name, i),  64'(obs_l[i]), 64'(exp_l[i]));
    end
    chk({name, "/attempts"}, 64'(obs_gap.size()), 64'(exp_gap.size()));
    for (int i = 0; i < obs_gap.size() && i < exp_gap.size(); i++)
      chk($sformatf("%s/wait%0d", name, i), 64'(obs_gap[i]), 64'(exp_gap[i]));
    chk({name, "/sent_count"},    64'(nsent), 64'(exp_sent));
    chk({name, "/dropped_count"}, 64'(ndrop), 64'(exp_drop));
  endtask

  task automatic set_all(input int kind, input int dly);
    for (int k = 0; k <= MR; k++) begin
      rkind[k] = kind;
      rdly[k]  = dly;
    end
  endtask

  initial begin
    logic [FW-1:0] f;
    rst = 1'b1;
    bus.flit_valid = 1'b0; bus.flit_in = '0; bus.tx_ready = 1'b0;
    bus.ack_valid  = 1'b0; bus.ack_ok  = 1'b0;
    rdy_mode = 0; stray = 0;
    #1;
    chk_idle_outputs("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    set_all(1, 0);
    run_flit(64'h0123_4567_89AB_CDEF, "basic");

    rdy_mode = 2; set_all(1, 0);
    run_flit({$urandom, $urandom}, "backpressure");

    rdy_mode = 0; set_all(1, 3);
    rkind[0] = 2; rdly[0] = 1;
    rkind[1] = 2; rdly[1] = 5;
    run_flit({$urandom, $urandom}, "nack2_ack");

    set_all(0, 0);
    run_flit({$urandom, $urandom}, "no_response");

    stray = 1; set_all(1, 4);
    run_flit({$urandom, $urandom}, "stray");
    stray = 0;

    set_all(1, TMO - 1);
    run_flit({$urandom, $urandom}, "ack_on_timeout");

    set_all(2, TMO - 1);
    run_flit({$urandom, $urandom}, "nack_on_timeout");

    for (int n = 0; n < 6; n++) begin
      rdy_mode = $urandom_range(0, 2);
      stray    = 1'($urandom_range(0, 1));
      for (int k = 0; k <= MR; k++) begin
        rkind[k] = $urandom_range(0, 2);
        rdly[k]  = $urandom_range(0, TMO - 1);
      end
      run_flit({$urandom, $urandom}, $sformatf("rand%0d", n));
    end
    stray = 0; rdy_mode = 0;

    // reset while chunk 2 is on the link
    f = {$urandom, $urandom};
    chk("mid_reset/ready_before", 64'(bus.flit_ready), 64'd1);
    bus.flit_valid = 1'b1; bus.flit_in = f; bus.tx_ready = 1'b1;
    @(negedge clk);
    bus.flit_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_reset/chunk2", 64'(bus.tx_data), 64'(PW'(f >> (2 * PW))));
    #2 rst = 1'b1;
    #1;
    chk_idle_outputs("mid_reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_reset/ready_after", 64'(bus.flit_ready), 64'd1);
    chk("mid_reset/no_drop",     64'(bus.dropped),    64'd0);
    set_all(1, 0);
    run_flit({$urandom, $urandom}, "after_reset");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/flit_sender.md
Name: flit_sender

Overview:
- Drain end of a flit_queue: pops one flit at a time over the queue's pop-side valid/ready handshake.
- Serializes each flit into PHY_WIDTH chunks onto the outgoing link.
- Waits for a per-flit ack/nack from the far end. Retransmits on nack or timeout, up to MAX_RETRY times, then drops the flit.
- Sits between a router output flit_queue and the physical link driver.

Parameters:
- FLIT_WIDTH, 64, flit width in bits; equals $bits(types::flit_t); must be an integer multiple of PHY_WIDTH.
- PHY_WIDTH, 16, link data width per beat.
- TIMEOUT, 32, cycles in WAIT_ACK with no ack_valid before a timeout is declared; must be ≥1.
- MAX_RETRY, 3, retransmissions allowed after the first attempt; 0 means no retransmission.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- flit_valid  in  1  queue has a flit; connects to flit_queue poped_flit_valid.
- flit_in  in  FLIT_WIDTH  flit from queue (types::flit_t).
- flit_ready  out  1  sender accepts a flit; connects to flit_queue poped_flit_ready.
- tx_valid  out  1  tx_data is valid.
- tx_data  out  PHY_WIDTH  current chunk.
- tx_last  out  1  current chunk is the final chunk of the flit.
- tx_ready  in  1  link accepts the chunk.
- ack_valid  in  1  far end returns a response this cycle.
- ack_ok  in  1  1 = ack, 0 = nack; sampled only when ack_valid = 1.
- sent  out  1  one-cycle pulse: flit acknowledged.
- dropped  out  1  one-cycle pulse: flit abandoned after retries exhausted.
- busy  out  1  state != IDLE.

Behaviour:
- Derived values:
  - NCHUNK = FLIT_WIDTH/PHY_WIDTH.
  - chunk_idx width = clog2(NCHUNK), minimum 1.
  - retry_cnt width = clog2(MAX_RETRY+1), minimum 1.
  - timeout counter width = clog2(TIMEOUT+1).
- Reset (asynchronous, while rst = 1):
  - State = IDLE; all counters = 0; flit register = 0.
  - flit_ready, tx_valid, tx_last, sent, dropped and busy are all 0.
  - tx_data = 0.
  - Reset asserted mid-flit abandons the flit silently, with no dropped pulse.
- State machine: IDLE, SEND, WAIT_ACK.
- IDLE:
  - flit_ready = 1 (decoded from registered state only; no combinational path from any input).
  - On flit_valid & flit_ready: latch flit_in, set chunk_idx = 0, retry_cnt = 0, go to SEND.
  - Flit accepted on edge N → tx_valid = 1 in cycle N+1.
- SEND:
  - flit_ready = 0.
  - tx_valid = 1, tx_data = flit[chunk_idx*PHY_WIDTH +: PHY_WIDTH], sent LSB chunk first.
  - tx_last = (chunk_idx == NCHUNK-1).
  - tx_data and tx_last stay stable while tx_ready = 0.
  - On tx_valid & tx_ready:
    - Not last chunk: chunk_idx++.
    - Last chunk: chunk_idx = 0, timeout counter = 0, go to WAIT_ACK.
- WAIT_ACK:
  - tx_valid = 0.
  - Timeout counter increments each cycle without ack_valid.
  - ack_valid & ack_ok: sent pulse next cycle; go to IDLE.
  - ack_valid & !ack_ok, or counter reaches TIMEOUT (failure):
    - If retry_cnt < MAX_RETRY: retry_cnt++, go to SEND with chunk_idx = 0, retransmitting the latched flit unchanged.
    - Else: dropped pulse next cycle; go to IDLE.
  - ack_valid on the same cycle the counter reaches TIMEOUT: the response wins (ack → sent; nack → failure path once, not counted twice).
- Responses outside WAIT_ACK: ack_valid in IDLE or SEND is ignored and has no effect.
- Pulses: sent and dropped are registered, high for exactly one cycle, and mutually exclusive.
- Back-to-back flits: the IDLE cycle after a sent/drop decision is mandatory, so minimum flit period = 1 + NCHUNK + 1 cycles with immediate tx_ready and ack.
- Flit register is written only in IDLE; flit_in changes during SEND/WAIT_ACK do not affect transmission.

Test Plan:
- Single flit 64'h0123_4567_89AB_CDEF, tx_ready = 1, ack_ok on first WAIT_ACK cycle:
  - Chunks in order 16'hCDEF, 16'h89AB, 16'h4567, 16'h0123.
  - tx_last only on 16'h0123.
  - sent pulses once; flit_ready returns high.
- Backpressure: tx_ready toggles 0,1,0,0,1,… → each chunk is held stable until the handshake; no chunk is skipped or duplicated; 4 handshakes total.
- Nack twice then ack → 12 chunk handshakes total (3 identical transmissions), one sent pulse, dropped stays 0.
- No response, MAX_RETRY = 3 → 4 transmissions, each followed by 32 WAIT_ACK cycles; then one dropped pulse and return to IDLE.
- Stray and simultaneous responses:
  - ack_valid = 1 during SEND → ignored; transmission completes normally.
  - ack on the TIMEOUT cycle → sent, no retransmission.
- Reset during chunk 2 of a flit:
  - All outputs go to 0 immediately.
  - After release, flit_ready = 1; the next flit transmits from chunk 0; no dropped pulse.
